// File: rtl/output_collector_node1.sv
// Node 1 return-path collector: arbitrates twelve response sources and
// serialises their payloads onto one 16-bit outbound word stream.
module output_collector_node1 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [11:0]  src_valid,
  input  logic [191:0] src_data,
  output logic [11:0]  src_ack,
  output logic [15:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [3:0]   grant_id
);

  localparam int unsigned NUM_SRC  = 12;
  localparam int unsigned NUM_RR   = 11;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned PAY_W    = 8;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned SEQ_W    = 4;
  localparam int unsigned CAND_W   = 5;
  localparam logic [IDX_W-1:0] ESPIC_IDX = IDX_W'(11);
  localparam logic [IDX_W-1:0] LAST_RR   = IDX_W'(10);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [SEQ_W-1:0]   seq;
  logic [IDX_W-1:0]   rr;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [CAND_W-1:0]  cand;
  logic [3:0]         win_code;
  logic [PAY_W-1:0]   win_payload;
  logic [IDX_W-1:0]   next_rr;

  // Source bits [15:8] are overwritten by the collector and never read.
  logic [NUM_SRC*PAY_W-1:0] src_hi_unused;

  always_comb begin
    src_hi_unused = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_hi_unused[i*PAY_W +: PAY_W] = src_data[i*WORD_W+PAY_W +: PAY_W];
    end
  end

  function automatic logic [3:0] code_of(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(6))       code_of = 4'(idx + IDX_W'(1));
    else if (idx < IDX_W'(11)) code_of = 4'(idx + IDX_W'(4));
    else                       code_of = 4'hF;
  endfunction

  // ESPIC wins outright; otherwise round-robin over 0..10 starting at rr.
  // Scanning from the far end lets the nearest valid index overwrite last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (src_valid[ESPIC_IDX]) begin
      win_valid = 1'b1;
      win_idx   = ESPIC_IDX;
    end else begin
      for (int i = int'(NUM_RR) - 1; i >= 0; i--) begin
        cand = CAND_W'(rr) + CAND_W'(i);
        if (cand >= CAND_W'(NUM_RR)) cand = cand - CAND_W'(NUM_RR);
        if (src_valid[cand[IDX_W-1:0]]) begin
          win_valid = 1'b1;
          win_idx   = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    win_code    = code_of(win_idx);
    win_payload = src_data[{win_idx, 4'h0} +: PAY_W];
    next_rr     = (win_idx == LAST_RR) ? '0 : IDX_W'(win_idx + IDX_W'(1));
  end

  // Collector FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seq       <= '0;
      rr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
      src_ack   <= '0;
    end else begin
      src_ack <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            out_data  <= {seq, win_code, win_payload};
            out_valid <= 1'b1;
            busy      <= 1'b1;
            grant_id  <= win_code;
            src_ack   <= NUM_SRC'(1) << win_idx;
            if (win_idx != ESPIC_IDX) rr <= next_rr;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= '0;
            seq       <= SEQ_W'(seq + SEQ_W'(1));
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
